// File: rtl/ifetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue: state encodings,
// the JAL opcode, the queued entry layout and the J-type immediate decode.
package ifetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [6:0] JAL_TYPE = 7'b1101111;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  // J-type immediate: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended
  function automatic logic signed [PC_W-1:0] jal_imm(input logic [INST_W-1:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_queue_inst_fifo.sv
// Circular-buffer FIFO with occupancy count; storage is not reset, only the
// pointers and count are. Clear wins over push and pop.
module inst_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, keeps at most one cache request in flight,
// predecodes JAL for redirection and queues {inst, pc} pairs for the decoder.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in
);

  if_state_e    state;
  if_state_e    state_nx;
  logic [31:0]  fetch_pc;
  logic [31:0]  next_pc;
  logic         resp_take;
  logic         q_push;
  logic         q_pop;
  logic         q_clear;
  logic         q_empty;
  logic         q_full;
  fetch_entry_t q_din;
  fetch_entry_t q_head;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state <= IF_IDLE;
    else if (rdy_in) state <= state_nx;
  end

  // A response arriving together with a flush still retires the in-flight
  // request, so WAIT returns to IDLE rather than waiting in DROP forever.
  always_comb begin
    state_nx = state;
    unique case (state)
      IF_IDLE: if (!flush_in && !q_full) state_nx = IF_WAIT;
      IF_WAIT: begin
        if (ic_resp_valid) state_nx = IF_IDLE;
        else if (flush_in) state_nx = IF_DROP;
      end
      IF_DROP: if (ic_resp_valid) state_nx = IF_IDLE;
      default: state_nx = IF_IDLE;
    endcase
  end

  always_comb begin
    ic_req_valid = (state == IF_WAIT);
  end

  always_comb begin
    next_pc = fetch_pc + 32'd4;
    if (ic_resp_inst[6:0] == JAL_TYPE) next_pc = fetch_pc + $unsigned(jal_imm(ic_resp_inst));
  end

  assign resp_take = (state == IF_WAIT) && ic_resp_valid && !flush_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc <= RESET_PC;
    end else if (rdy_in) begin
      if (flush_in)       fetch_pc <= flush_pc_in;
      else if (resp_take) fetch_pc <= next_pc;
    end
  end

  assign ic_req_addr = fetch_pc;

  assign q_push  = rdy_in && resp_take;
  assign q_pop   = rdy_in && inst_ready && !q_empty && !flush_in;
  assign q_clear = rdy_in && flush_in;
  assign q_din   = '{inst: ic_resp_inst, pc: fetch_pc};

  inst_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (q_push),
    .pop   (q_pop),
    .clear (q_clear),
    .din   (q_din),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  assign inst_valid = !q_empty;
  assign inst       = q_head.inst;
  assign inst_pc    = q_head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a behavioural cache with variable latency
// feeds the DUT and a scoreboard queue predicts every dequeued {inst, pc}.
module tb_ifetch_queue;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        flush_in;
  logic [31:0] flush_pc_in;

  ifetch_queue #(
    .QUEUE_DEPTH (8),
    .RESET_PC    (32'h0)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_inst  (ic_resp_inst),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .flush_in      (flush_in),
    .flush_pc_in   (flush_pc_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // cache and reference model state
  logic [31:0] imem [logic [31:0]];
  logic [63:0] expq [$];
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  logic [31:0] last_cap_addr;
  logic        pend;
  logic        dropped;
  int          cnt;
  int          lat;
  int          caps;
  int          cyc;
  int          last_cap_cyc;
  int          gap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h00000013;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] imm;
    imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    if (w[6:0] == 7'h6F) return pc + imm;
    return pc + 32'd4;
  endfunction

  // One clock: check visible head, play cache, predict the edge, advance.
  task automatic cycle();
    logic has_head;
    cyc++;
    has_head = (expq.size() != 0);
    chk("inst_valid", 64'(inst_valid), 64'(has_head));
    if (has_head) chk("head", {inst, inst_pc}, expq[0]);
    if (!pend && ic_req_valid) begin
      chk("req_addr", 64'(ic_req_addr), 64'(exp_pc));
      pend = 1'b1;
      dropped = 1'b0;
      cnt = 0;
      pend_addr = ic_req_addr;
      caps++;
      last_cap_addr = ic_req_addr;
      gap = cyc - last_cap_cyc;
      last_cap_cyc = cyc;
    end
    ic_resp_valid = pend && (cnt >= lat);
    ic_resp_inst  = ic_resp_valid ? mem_word(pend_addr) : 32'hdeadbeef;
    if (rdy_in) begin
      if (flush_in) begin
        expq.delete();
        exp_pc = flush_pc_in;
        if (pend && !ic_resp_valid) dropped = 1'b1;
      end else begin
        if (inst_ready && has_head) void'(expq.pop_front());
        if (ic_resp_valid && !dropped) begin
          expq.push_back({ic_resp_inst, exp_pc});
          exp_pc = ref_next(exp_pc, ic_resp_inst);
        end
      end
      if (ic_resp_valid) pend = 1'b0;
      else if (pend) cnt++;
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic run_until_cap(input string tag, input int budget);
    int c0;
    int n;
    c0 = caps;
    n = 0;
    while (caps == c0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(caps == c0), 64'(0));
  endtask

  task automatic model_reset();
    expq.delete();
    exp_pc = 32'h0;
    pend = 1'b0;
    dropped = 1'b0;
    cnt = 0;
  endtask

  initial begin
    int n;
    int c0;
    rst_in = 1'b1;
    rdy_in = 1'b0;
    inst_ready = 1'b0;
    flush_in = 1'b0;
    flush_pc_in = 32'h0;
    ic_resp_valid = 1'b0;
    ic_resp_inst = 32'h0;
    lat = 0;
    caps = 0;
    cyc = 0;
    last_cap_cyc = 0;
    gap = 0;
    last_cap_addr = 32'h0;
    pend_addr = 32'h0;
    model_reset();
    imem[32'h8] = 32'h1000006F;

    repeat (2) @(negedge clk_in);
    chk("rst_req_valid", 64'(ic_req_valid), 64'(0));
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_req_addr", 64'(ic_req_addr), 64'(32'h0));
    rst_in = 1'b0;
    rdy_in = 1'b1;

    // 1-cycle cache streaming addi, then the JAL at 0x8 redirects to 0x108
    run_until_cap("t1_cap1", 10);
    chk("t1_addr0", 64'(last_cap_addr), 64'(32'h0));
    run_until_cap("t1_cap2", 10);
    chk("t1_head_pc", 64'(inst_pc), 64'(32'h0));
    chk("t1_gap2", 64'(gap), 64'(2));
    run_until_cap("t1_cap3", 10);
    chk("t1_addr8", 64'(last_cap_addr), 64'(32'h8));
    chk("t1_gap3", 64'(gap), 64'(2));
    run_until_cap("t2_cap4", 10);
    chk("t2_jal_target", 64'(last_cap_addr), 64'(32'h108));
    inst_ready = 1'b1;
    cycle();
    cycle();
    inst_ready = 1'b0;
    chk("t2_jal_head", {inst, inst_pc}, {32'h1000006F, 32'h8});

    // fill the queue from 0x0 with stalled consumer
    imem.delete(32'h8);
    flush_in = 1'b1;
    flush_pc_in = 32'h0;
    cycle();
    flush_in = 1'b0;
    n = 0;
    while (expq.size() < 8 && n < 200) begin
      cycle();
      n++;
    end
    chk("t3_fill_timeout", 64'(expq.size() < 8), 64'(0));
    c0 = caps;
    repeat (6) cycle();
    chk("t3_full_noreq", 64'(ic_req_valid), 64'(0));
    chk("t3_no_new_caps", 64'(caps - c0), 64'(0));
    chk("t3_head_pc", 64'(inst_pc), 64'(32'h0));
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    c0 = caps;
    run_until_cap("t3_refill_cap", 10);
    chk("t3_refill_addr", 64'(last_cap_addr), 64'(32'h20));
    repeat (8) cycle();
    chk("t3_one_request", 64'(caps - c0), 64'(1));
    chk("t3_full_again", 64'(ic_req_valid), 64'(0));

    // flush while a 2-cycle response is in flight
    lat = 1;
    inst_ready = 1'b1;
    n = 0;
    while (!(!pend && ic_req_valid) && n < 50) begin
      cycle();
      n++;
    end
    chk("t4_wait_timeout", 64'(n >= 50), 64'(0));
    inst_ready = 1'b0;
    flush_in = 1'b1;
    flush_pc_in = 32'h400;
    cycle();
    flush_in = 1'b0;
    chk("t4_empty", 64'(inst_valid), 64'(0));
    chk("t4_drop_noreq", 64'(ic_req_valid), 64'(0));
    run_until_cap("t4_cap", 10);
    chk("t4_redirect", 64'(last_cap_addr), 64'(32'h400));
    n = 0;
    while (expq.size() == 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_first_pc", 64'(inst_pc), 64'(32'h400));

    // flush, response and pop in the same cycle
    lat = 0;
    n = 0;
    while (!(!pend && ic_req_valid && expq.size() != 0) && n < 50) begin
      cycle();
      n++;
    end
    chk("t5_wait_timeout", 64'(n >= 50), 64'(0));
    flush_in = 1'b1;
    flush_pc_in = 32'h800;
    inst_ready = 1'b1;
    cycle();
    flush_in = 1'b0;
    inst_ready = 1'b0;
    chk("t5_empty", 64'(inst_valid), 64'(0));
    run_until_cap("t5_cap", 10);
    chk("t5_redirect", 64'(last_cap_addr), 64'(32'h800));

    // freeze mid-request for 5 cycles, then resume streaming
    lat = 2;
    inst_ready = 1'b1;
    run_until_cap("t6_cap", 10);
    rdy_in = 1'b0;
    repeat (5) begin
      cycle();
      chk("t6_req_hold", 64'(ic_req_valid), 64'(1));
      chk("t6_addr_hold", 64'(ic_req_addr), 64'(exp_pc));
    end
    rdy_in = 1'b1;
    c0 = caps;
    repeat (20) cycle();
    chk("t6_resumed", 64'(caps - c0 >= 4), 64'(1));

    // asynchronous reset in the middle of WAIT
    lat = 3;
    inst_ready = 1'b0;
    run_until_cap("t7_cap", 10);
    cycle();
    #2;
    rst_in = 1'b1;
    ic_resp_valid = 1'b0;
    #1;
    chk("t7_req_valid", 64'(ic_req_valid), 64'(0));
    chk("t7_inst_valid", 64'(inst_valid), 64'(0));
    chk("t7_req_addr", 64'(ic_req_addr), 64'(32'h0));
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    lat = 0;
    run_until_cap("t7_restart_cap", 10);
    chk("t7_restart_addr", 64'(last_cap_addr), 64'(32'h0));
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Owns the fetch PC and issues one word request at a time to the instruction cache.
- Predecodes JAL to redirect the fetch PC; all other instructions advance PC+4.
- Buffers fetched {inst, pc} pairs in a FIFO. The FIFO head drives the decoder; dispatch pops it. A flush empties the queue and redirects fetch.

Parameters:
- QUEUE_DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global enable; when 0 all state is frozen
- ic_req_valid  output  1  fetch request pending
- ic_req_addr  output  32  fetch address (= fetch_pc)
- ic_resp_valid  input  1  one-cycle pulse: ic_resp_inst is valid
- ic_resp_inst  input  32  fetched instruction word
- inst_valid  output  1  queue head valid (queue non-empty)
- inst  output  32  head instruction, to decoder
- inst_pc  output  32  head PC
- inst_ready  input  1  consumer accepts the head this cycle
- flush_in  input  1  mispredict/redirect
- flush_pc_in  input  32  redirect target

Behaviour:
- Reset (asynchronous, rst_in=1):
  - fetch_pc = RESET_PC; state = IDLE; queue empty (head = tail = count = 0).
  - ic_req_valid = 0; inst_valid = 0; ic_req_addr = RESET_PC.
- Clock enable: all register updates are qualified by rdy_in=1. The cache shares rdy_in and holds its response while rdy_in=0.
- FSM states IDLE, WAIT, DROP; at most one outstanding request at any time.
  - IDLE: if !flush_in and count < QUEUE_DEPTH, go to WAIT. ic_req_valid = 0.
  - WAIT: ic_req_valid = 1; ic_req_addr = fetch_pc and stays stable.
    - On ic_resp_valid: push {ic_resp_inst, fetch_pc}; fetch_pc <= next_pc; go to IDLE.
    - If flush_in is asserted: go to DROP.
  - DROP: ic_req_valid = 0. The cache still returns the in-flight response; on ic_resp_valid, discard it and go to IDLE.
  - A flush in DROP keeps the state in DROP.
- next_pc:
  - If ic_resp_inst[6:0] == 7'b1101111 (JAL): fetch_pc + immJ, where immJ = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Otherwise: fetch_pc + 4.
  - All additions wrap modulo 2^32.
- Throughput: one instruction per 2 cycles with a 1-cycle cache (IDLE→WAIT, response, IDLE). Deeper cache latency holds WAIT.
- Pop: inst_valid && inst_ready && rdy_in. inst and inst_pc are a combinational read of the head entry.
- Push and pop in the same cycle: both occur and count is unchanged. Push into a full queue cannot happen, because a request is issued only when count < QUEUE_DEPTH and only one is outstanding.
- Flush (flush_in=1, rdy_in=1) has priority over push and pop in the same cycle:
  - Queue emptied; the response arriving that cycle is discarded.
  - fetch_pc <= flush_pc_in.
  - From IDLE, the first request to flush_pc_in is issued the following cycle.
  - inst_valid is 0 from the next cycle.
- Pointers wrap modulo QUEUE_DEPTH. count is $clog2(QUEUE_DEPTH)+1 bits wide.
- Reset mid-request: state returns to IDLE immediately. The cache is reset by the same rst_in, so no stale response is expected.

Decomposition:
- Opcode constant for JAL: use the existing Jal_type in defines.v.
- New constants in defines.v: IF_IDLE/IF_WAIT/IF_DROP state encodings (2-bit) and the instruction width.
- Sub-module: inst_fifo.
  - Parameterised depth/width, circular buffer with count.
  - Ports: push, pop, clear, din, dout, empty, full.
  - ifetch_queue contains the FSM and PC logic only.

Test Plan:
1. Reset, then rdy_in=1 with a 1-cycle cache returning 32'h00000013 (addi) → requests at 0x0, 0x4, 0x8, one every 2 cycles; inst_valid rises with inst_pc = 0x0.
2. Word at 0x8 = JAL +0x100 (32'h1000006F) → next ic_req_addr = 0x108; the queue holds the JAL with inst_pc = 0x8.
3. inst_ready held 0 → queue fills to QUEUE_DEPTH = 8 entries (PCs 0x0–0x1C) and ic_req_valid stays 0. Then one pop → exactly one new request, for 0x20.
4. flush_in with flush_pc_in = 0x400 during WAIT (response due next cycle) → late response discarded, inst_valid = 0, next request address = 0x400, first queued inst_pc = 0x400.
5. Same cycle: flush_in, ic_resp_valid and pop → queue empty afterwards, nothing pushed, fetch_pc = flush_pc_in.
6. rdy_in=0 for 5 cycles mid-stream → no pointer, PC or state change. The sequence resumes identically once rdy_in=1.
7. Assert rst_in asynchronously mid-WAIT → outputs return to reset values without a clock edge.
